// File: rtl/det_run_logger_pkg.sv
// Shared types and default sizing for the run-length logger.
package det_pkg;

  // Run measurement FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SKIP = 2'd2
  } run_state_t;

  localparam int DEF_LEN_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers. The head word is
// visible on dout whenever empty is low. A push is accepted while full
// only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags and accepted push/pop decode.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointer update; flush empties the FIFO and wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush && rst_n) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Show-ahead head word, forced to zero while empty.
  always_comb begin
    if (empty) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

endmodule

// File: rtl/det_run_logger.sv
// Measures each contiguous high run of the detector output and queues
// one saturated run-length record per completed run.
module det_run_logger
  import det_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det,
  input  logic             clr,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [LEN_W-1:0] rec_len,
  output logic [CNT_W-1:0] run_cnt,
  output logic             ovf,
  output logic             active
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  run_state_t       state_r;
  run_state_t       next_state_s;
  logic [LEN_W-1:0] len_r;
  logic [CNT_W-1:0] run_cnt_r;
  logic             ovf_r;
  logic             complete_s;
  logic             active_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  // State register; clr discards any run still high by parking in SKIP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (clr) begin
      state_r <= det ? SKIP : IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode from the sampled detector level.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = det ? RUN  : IDLE;
      RUN:     next_state_s = det ? RUN  : IDLE;
      SKIP:    next_state_s = det ? SKIP : IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: completion event, FIFO push/pop and drop qualification.
  always_comb begin
    active_s   = (state_r == RUN);
    complete_s = (state_r == RUN) && !det;
    pop_s      = !fifo_empty_s && rec_ready && !clr;
    push_s     = complete_s && !clr;
    drop_s     = push_s && fifo_full_s && !pop_s;
  end

  // Run-length counter: starts at 1 on entry, saturates at LEN_MAX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_r <= {LEN_W{1'b0}};
    end else if (clr) begin
      len_r <= {LEN_W{1'b0}};
    end else if (state_r == IDLE && det) begin
      len_r <= {{(LEN_W-1){1'b0}}, 1'b1};
    end else if (state_r == RUN && det && len_r != LEN_MAX) begin
      len_r <= len_r + {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      len_r <= len_r;
    end
  end

  // Completed-run counter and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt_r <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
    end else if (clr) begin
      run_cnt_r <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      if (push_s && run_cnt_r != CNT_MAX) begin
        run_cnt_r <= run_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push_s),
    .din   (len_r),
    .pop   (pop_s),
    .dout  (rec_len),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign rec_valid = !fifo_empty_s;
  assign run_cnt   = run_cnt_r;
  assign ovf       = ovf_r;
  assign active    = active_s;

endmodule

// File: tb/tb_det_run_logger.sv
// Directed bench for det_run_logger: a default instance and a LEN_W=3
// instance share the same stimulus.
module tb_det_run_logger;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        det = 1'b0;
  logic        clr = 1'b0;
  logic        rec_ready = 1'b0;

  logic        rec_valid;
  logic [7:0]  rec_len;
  logic [15:0] run_cnt;
  logic        ovf;
  logic        active;

  logic        s_rec_valid;
  logic [2:0]  s_rec_len;
  logic [15:0] s_run_cnt;
  logic        s_ovf;
  logic        s_active;

  int checks = 0;
  int errors = 0;
  int act_cycles = 0;

  always #5 clk = ~clk;

  det_run_logger dut (
    .clk (clk), .rst_n (rst_n), .det (det), .clr (clr),
    .rec_valid (rec_valid), .rec_ready (rec_ready), .rec_len (rec_len),
    .run_cnt (run_cnt), .ovf (ovf), .active (active)
  );

  det_run_logger #(.LEN_W(3)) dut_s (
    .clk (clk), .rst_n (rst_n), .det (det), .clr (clr),
    .rec_valid (s_rec_valid), .rec_ready (rec_ready), .rec_len (s_rec_len),
    .run_cnt (s_run_cnt), .ovf (s_ovf), .active (s_active)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic d, input logic rr);
    det = d;
    rec_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset(input string tag);
    check_eq({tag, "_valid"}, {31'd0, rec_valid}, 32'd0);
    check_eq({tag, "_len"}, {24'd0, rec_len}, 32'd0);
    check_eq({tag, "_cnt"}, {16'd0, run_cnt}, 32'd0);
    check_eq({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    check_eq({tag, "_active"}, {31'd0, active}, 32'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(1'b0, 1'b0);
    clr = 1'b0;
  endtask

  initial begin
    // reset
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    expect_reset("rst");
    rst_n = 1'b1;

    // single run of 3
    act_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      if (active) act_cycles++;
    end
    cyc(1'b0, 1'b1);
    if (active) act_cycles++;
    check_eq("t1_active_cycles", act_cycles, 32'd3);
    check_eq("t1_valid", {31'd0, rec_valid}, 32'd1);
    check_eq("t1_len", {24'd0, rec_len}, 32'd3);
    check_eq("t1_len_s", {29'd0, s_rec_len}, 32'd3);
    check_eq("t1_cnt", {16'd0, run_cnt}, 32'd1);
    cyc(1'b0, 1'b1);
    check_eq("t1_popped", {31'd0, rec_valid}, 32'd0);

    // pattern 1,0,1,1,0 without ready, then two pops
    do_clr();
    check_eq("t2_clr_cnt", {16'd0, run_cnt}, 32'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check_eq("t2_valid", {31'd0, rec_valid}, 32'd1);
    check_eq("t2_head1", {24'd0, rec_len}, 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check_eq("t2_cnt", {16'd0, run_cnt}, 32'd2);
    check_eq("t2_head_held", {24'd0, rec_len}, 32'd1);
    cyc(1'b0, 1'b1);
    check_eq("t2_head2", {24'd0, rec_len}, 32'd2);
    check_eq("t2_valid2", {31'd0, rec_valid}, 32'd1);
    cyc(1'b0, 1'b1);
    check_eq("t2_empty", {31'd0, rec_valid}, 32'd0);

    // overflow: 5 runs of 1 into DEPTH 4
    do_clr();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      if (i == 3) check_eq("t3_no_ovf_yet", {31'd0, ovf}, 32'd0);
    end
    check_eq("t3_ovf", {31'd0, ovf}, 32'd1);
    check_eq("t3_cnt", {16'd0, run_cnt}, 32'd5);
    // 6th run (length 2) completes with a simultaneous pop
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check_eq("t3_cnt6", {16'd0, run_cnt}, 32'd6);
    check_eq("t3_ovf_sticky", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_drain_one", {24'd0, rec_len}, 32'd1);
      cyc(1'b0, 1'b1);
    end
    check_eq("t3_sixth_len", {24'd0, rec_len}, 32'd2);
    check_eq("t3_sixth_valid", {31'd0, rec_valid}, 32'd1);
    cyc(1'b0, 1'b1);
    check_eq("t3_drained", {31'd0, rec_valid}, 32'd0);

    // saturation: 10 cycles high
    do_clr();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    check_eq("t4_active", {31'd0, active}, 32'd1);
    cyc(1'b0, 1'b0);
    check_eq("t4_len8", {24'd0, rec_len}, 32'd10);
    check_eq("t4_len3_sat", {29'd0, s_rec_len}, 32'd7);
    check_eq("t4_cnt", {16'd0, run_cnt}, 32'd1);

    // clr mid-run: run discarded, stale record and count cleared
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    clr = 1'b1;
    cyc(1'b1, 1'b0);
    clr = 1'b0;
    check_eq("t5_active_skip", {31'd0, active}, 32'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check_eq("t5_skip_active", {31'd0, active}, 32'd0);
    cyc(1'b0, 1'b0);
    check_eq("t5_no_rec", {31'd0, rec_valid}, 32'd0);
    check_eq("t5_cnt", {16'd0, run_cnt}, 32'd0);
    check_eq("t5_ovf", {31'd0, ovf}, 32'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check_eq("t5_len", {24'd0, rec_len}, 32'd1);
    check_eq("t5_cnt1", {16'd0, run_cnt}, 32'd1);

    // reset mid-run with two records held
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check_eq("t6_cnt2", {16'd0, run_cnt}, 32'd2);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0);
    expect_reset("t6_rst");
    rst_n = 1'b1;
    cyc(1'b1, 1'b0);
    check_eq("t6_restart_active", {31'd0, active}, 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check_eq("t6_len", {24'd0, rec_len}, 32'd2);
    check_eq("t6_cnt", {16'd0, run_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/det_run_logger.md
# det_run_logger

Downstream consumer of the consecutive-ones sequence detector. It samples the detector's `dout` level (`det`), measures each contiguous high run in cycles, and queues one run-length record per completed run into a small FIFO. The FIFO drains over a valid/ready interface. The block also keeps a saturating count of completed runs and a sticky overflow flag for host/status logic.

## Interface
Parameters:
- `LEN_W`, 8: run-length field width; length saturates at 2^LEN_W-1.
- `CNT_W`, 16: completed-run counter width; saturating.
- `DEPTH`, 4: record FIFO depth. Power of two, ≥2.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `det` in 1: detector `dout`, registered upstream. Level, not a pulse.
- `clr` in 1: synchronous soft clear. Takes effect only when `rst_n`=1.
- `rec_valid` out 1: FIFO head holds a record.
- `rec_ready` in 1: consumer accepts the head when `rec_valid`&&`rec_ready`.
- `rec_len` out LEN_W: run length of the head record, in cycles.
- `run_cnt` out CNT_W: completed runs since reset/clr.
- `ovf` out 1: sticky; at least one record was dropped.
- `active` out 1: a run is currently being measured.

## Operation
- States:
  - IDLE: waiting for a run.
  - RUN: measuring a run.
  - SKIP: discarding a run truncated by `clr`.
- IDLE:
  - `det`=1 → RUN, `len`←1.
  - Otherwise stay.
- RUN:
  - `det`=1 → `len`←min(`len`+1, 2^LEN_W-1).
  - `det`=0 → completion event, → IDLE.
- SKIP:
  - `det`=0 → IDLE.
  - Otherwise stay; nothing is measured.
- Completion event:
  - `run_cnt`←min(`run_cnt`+1, 2^CNT_W-1). Counts every completed run, including dropped ones.
  - FIFO not full, or full with a pop in the same cycle → push `len`.
  - Otherwise drop the record and set `ovf`←1.
- Pop: `rec_valid`&&`rec_ready` removes the head. `rec_ready` while `rec_valid`=0 is ignored.
- `clr`:
  - Flush FIFO; `run_cnt`←0; `ovf`←0; `len`←0.
  - State → SKIP if `det`=1, else IDLE. A run already in progress is never recorded.
  - `clr` overrides a same-cycle completion event and a same-cycle pop.
- `active` = (state==RUN).
- `rec_len` is held stable while `rec_valid`=1 and not popped.

## Timing
- Reset values: state IDLE, `len` 0, FIFO empty, `rec_valid` 0, `rec_len` 0, `run_cnt` 0, `ovf` 0, `active` 0.
- Reset mid-run: run discarded; state IDLE even if `det`=1. The next run starts on the first edge where `rst_n`=1 and `det`=1. That run's length is counted from that edge.
- Run length = number of rising edges at which `det` was sampled 1 in RUN, including the IDLE→RUN edge.
- Completion edge:
  - Edge where `det`=0 is sampled in RUN.
  - `run_cnt`, `ovf` and FIFO contents update on that edge.
  - `active` falls on that edge.
  - If the FIFO was empty, `rec_valid`=1 from that edge.
- `active` rises on the IDLE→RUN edge.
- Minimum pattern `det`=1,0,1,0: two length-1 records. Back-to-back runs need no gap beyond the single 0 cycle.
- Throughput: one push and one pop per cycle sustained. The FIFO has registered outputs and no combinational path from `rec_ready` to `rec_valid`.

## Structure
- Shared package `det_pkg`:
  - state enum `run_state_t` {IDLE, RUN, SKIP};
  - default `LEN_W`/`CNT_W`/`DEPTH` localparams.
- Sub-module `sync_fifo`:
  - parameters: width, depth;
  - ports: push, pop, flush, full, empty;
  - show-ahead read, power-of-two pointers with an extra wrap bit.
- Top level holds: the FSM, the `len` saturating counter, the `run_cnt` saturating counter, `ovf` and the `clr` handling.

## Test plan
- Reset, `det`=1 for 3 cycles then 0, `rec_ready`=1 → one record `rec_len`=3; `run_cnt`=1; `active` high exactly 3 cycles.
- `det` pattern 1,0,1,1,0 with `rec_ready`=0 → `rec_valid`=1 with head 1; after two pops, values 1 then 2; `run_cnt`=2.
- `rec_ready`=0, 5 runs of length 1 with DEPTH=4 → 4 records (all 1) retained; `ovf`=1; `run_cnt`=5; then pop while a 6th run completes → 6th record accepted, no new drop.
- LEN_W=3, `det` high for 10 cycles → `rec_len`=7 (saturated).
- `clr` during a run of length 2 with `det` still high for 3 more cycles → no record; `run_cnt`=0; `ovf`=0; next 1-cycle run → `rec_len`=1.
- `rst_n`=0 for 1 cycle mid-run with FIFO holding 2 records → all outputs at reset values next cycle; FIFO empty.
